// File: rtl/riscv_pkg.sv
// Shared RISC-V softcore definitions: fetch FSM states, NOP encoding and
// instruction field positions used by fetch and decode.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          OP_LSB        = 0;
  localparam int          OP_MSB        = 6;
  localparam int          FUNCT3_LSB    = 12;
  localparam int          FUNCT7_B5_BIT = 30;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory port: valid/ready fetch request with a valid-only response.
interface instr_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC selection: sequential pc + 4 or taken-branch target.
// FETCH_MISALIGN_TRAP_EN keeps the raw target and flags low-bit misalignment.
module instr_fetch_next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  assign pc_plus4 = pc + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc    = pc_src ? pc_target : pc_plus4;
  assign misaligned = pc_src && (pc_target[1:0] != 2'b00);
`else
  // Without the trap a taken branch silently drops the byte offset.
  assign next_pc = pc_src ? (pc_target & ~XLEN'(3)) : pc_plus4;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it for decode.
// Define FETCH_MISALIGN_TRAP_EN to add fetch_misalign and a sticky FAULT state.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_if.master   imem,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_t    state;
  logic            req_valid;
  logic [XLEN-1:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned;
`endif

  instr_fetch_next_pc_sel #(
    .XLEN(XLEN)
  ) u_next_pc_sel (
    .pc        (pc),
    .pc_src    (pc_src),
    .pc_target (pc_target),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned(misaligned)
`endif
  );

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc;

  assign op        = instr[OP_MSB:OP_LSB];
  assign funct3    = instr[FUNCT3_LSB+2:FUNCT3_LSB];
  assign funct7_b5 = instr[FUNCT7_B5_BIT];

  // Handshake outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      req_valid   <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
        REQ: begin
          if (imem.imem_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            instr       <= imem.imem_rsp_data;
            state       <= HOLD;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              state          <= FAULT;
              fetch_misalign <= 1'b1;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
            end
`else
            state     <= REQ;
            req_valid <= 1'b1;
`endif
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-order PC model predicts every
// fetch address and delivered instruction; a monitor compares what the DUT presents.
module tb_instr_fetch;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BEQ_WORD = 32'h0063_0463;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_instr_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  instr_fetch_if #(.XLEN(XLEN)) imem ();

  instr_fetch #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .op         (op),
    .funct3     (funct3),
    .funct7_b5  (funct7_b5),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_src     (pc_src),
    .pc_target  (pc_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fetch_exp[$];
  exp_instr_t  instr_exp[$];
  logic [31:0] model_pc;
  bit          exp_fault;
  bit          mon_en;
  logic [31:0] mem[bit [31:0]];

  bit          mem_random;
  int          mem_stall;
  bit          mem_hold_rsp;
  bit          pending;
  logic [31:0] pending_addr;
  int          rsp_delay;

  bit          drv_random;
  int          stall_hold;
  bit          force_br;
  bit          force_src;
  logic [31:0] force_tgt;
  int          acc_count;
  int          consumed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic void pushFetch(input logic [31:0] a);
    exp_instr_t e;
    e.pc   = a;
    e.word = memWord(a);
    fetch_exp.push_back(a);
    instr_exp.push_back(e);
  endfunction

  // Program-order model: the next fetch follows the accepted branch decision.
  function automatic void modelAccept(input bit src, input logic [31:0] tgt);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (src && tgt[1:0] != 2'b00) begin
      exp_fault = 1'b1;
      model_pc  = tgt;
      return;
    end
`endif
    if (src) model_pc = {tgt[31:2], 2'b00};
    else     model_pc = model_pc + 32'd4;
    pushFetch(model_pc);
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = 32'($urandom_range(255)) << 2;
    if ($urandom_range(7) == 0) t = 32'hFFFF_FFFC;
`ifndef FETCH_MISALIGN_TRAP_EN
    else if ($urandom_range(3) == 0) t = t | 32'($urandom_range(3));
`endif
    return t;
  endfunction

  task automatic applyStimulus(input bit src, input logic [31:0] tgt, input int hold);
    force_src  = src;
    force_tgt  = tgt;
    force_br   = 1'b1;
    stall_hold = hold;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n     = 1'b0;
    rsp_delay = 0;
    fetch_exp.delete();
    instr_exp.delete();
    exp_fault = 1'b0;
    model_pc  = RESET_PC;
    pushFetch(RESET_PC);
    #1;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_op", 32'(op), 32'h13);
    checkOutput("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
    checkOutput("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!imem.imem_req_valid && n < 40);
    if (!imem.imem_req_valid) noteFail(name);
  endtask

  task automatic waitHold(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!instr_valid && n < 40);
    if (!instr_valid) noteFail(name);
  endtask

  // Instruction memory: optional request back-pressure and response latency.
  initial begin
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    pending             = 1'b0;
    forever begin
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = $urandom;
      if (pending) begin
        if (!mem_hold_rsp) begin
          if (rsp_delay == 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = memWord(pending_addr);
            pending             = 1'b0;
          end else begin
            rsp_delay--;
          end
        end
      end else if (mem_random && $urandom_range(3) == 0) begin
        imem.imem_rsp_valid = 1'b1;
      end
      if (rst_n && imem.imem_req_valid && !pending) begin
        if (mem_stall > 0) begin
          mem_stall--;
        end else if (!(mem_random && $urandom_range(2) == 0)) begin
          imem.imem_req_ready = 1'b1;
          pending             = 1'b1;
          pending_addr        = imem.imem_addr;
          rsp_delay           = mem_random ? int'($urandom_range(2)) : 0;
        end
      end else if (mem_random && !imem.imem_req_valid) begin
        imem.imem_req_ready = 1'($urandom_range(1));
      end
    end
  end

  // Decode side: consumes held instructions and supplies branch decisions.
  initial begin
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && stall_hold == 0 && !(drv_random && $urandom_range(3) == 0)) begin
        instr_ready = 1'b1;
        if (force_br) begin
          pc_src    = force_src;
          pc_target = force_tgt;
          force_br  = 1'b0;
        end else if (drv_random) begin
          pc_src    = 1'($urandom_range(1));
          pc_target = randTarget();
        end else begin
          pc_src    = 1'b0;
          pc_target = $urandom;
        end
        modelAccept(pc_src, pc_target);
      end else begin
        if (rst_n && instr_valid && stall_hold > 0) stall_hold--;
        instr_ready = instr_valid ? 1'b0 : 1'($urandom_range(1));
        pc_src      = 1'($urandom_range(1));
        pc_target   = $urandom;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_instr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        if (imem.imem_req_valid) begin
          if (fetch_exp.size() == 0) begin
            noteFail("unexpected_req");
          end else begin
            checkOutput("fetch_addr", imem.imem_addr, fetch_exp[0]);
            if (imem.imem_req_ready) begin
              void'(fetch_exp.pop_front());
              acc_count++;
            end
          end
        end
        if (instr_valid) begin
          if (instr_exp.size() == 0) begin
            noteFail("unexpected_instr");
          end else begin
            e = instr_exp[0];
            checkOutput("instr", instr, e.word);
            checkOutput("pc", pc, e.pc);
            checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
            checkOutput("op", 32'(op), 32'(e.word[6:0]));
            checkOutput("funct3", 32'(funct3), 32'(e.word[14:12]));
            checkOutput("funct7_b5", 32'(funct7_b5), 32'(e.word[30]));
            if (instr_ready) begin
              void'(instr_exp.pop_front());
              consumed++;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    noteFail("watchdog");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int acc0;
    int goal;
    int cyc;
    rst_n      = 1'b1;
    mon_en     = 1'b0;
    mem_random = 1'b0;
    mem_stall  = 0;
    mem_hold_rsp = 1'b0;
    drv_random = 1'b0;
    stall_hold = 0;
    force_br   = 1'b0;
    acc_count  = 0;
    consumed   = 0;
    mem[32'h0]  = 32'h0010_0093;
    mem[32'hC]  = BEQ_WORD;
    mem[32'h40] = BEQ_WORD;

    applyReset();
    mon_en = 1'b1;
    #3;
    checkOutput("idle_after_reset", 32'(imem.imem_req_valid), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #3;
      checkOutput("req_cadence", 32'(imem.imem_req_valid), 32'(k == 1 || k == 4));
      checkOutput("valid_cadence", 32'(instr_valid), 32'(k % 3 == 0));
    end

    mem_stall = 4;
    acc0 = acc_count;
    for (int k = 7; k <= 11; k++) begin
      @(negedge clk);
      #3;
      checkOutput("stall_req_valid", 32'(imem.imem_req_valid), 32'd1);
      checkOutput("stall_addr", imem.imem_addr, 32'h8);
    end
    repeat (2) @(negedge clk);
    #3;
    checkOutput("single_accept", 32'(acc_count - acc0), 32'd1);

    applyStimulus(1'b1, 32'h40, 5);
    waitHold("beq_hold");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #3;
      end
      checkOutput("hold_instr", instr, BEQ_WORD);
      checkOutput("hold_pc", pc, 32'hC);
      checkOutput("hold_op", 32'(op), 32'h63);
      checkOutput("hold_funct3", 32'(funct3), 32'd0);
      checkOutput("hold_funct7_b5", 32'(funct7_b5), 32'd0);
      checkOutput("hold_no_req", 32'(imem.imem_req_valid), 32'd0);
    end
    waitReq("taken_req");
    checkOutput("taken_addr", imem.imem_addr, 32'h40);
    applyStimulus(1'b0, 32'h80, 0);
    waitHold("not_taken_hold");
    waitReq("not_taken_req");
    checkOutput("not_taken_addr", imem.imem_addr, 32'h44);

    drv_random = 1'b1;
    mem_random = 1'b1;
    goal = consumed + 60;
    cyc  = 0;
    while (consumed < goal && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (consumed < goal) noteFail("random_progress");
    drv_random = 1'b0;
    mem_random = 1'b0;

    mem_hold_rsp = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      #3;
      cyc++;
    end while (!pending && cyc < 60);
    if (!pending) noteFail("reach_wait");
    applyReset();
    #3;
    mem_hold_rsp = 1'b0;
    waitReq("post_reset_req");
    checkOutput("post_reset_addr", imem.imem_addr, RESET_PC);
    applyStimulus(1'b1, 32'h42, 0);
    waitHold("post_reset_hold");
    checkOutput("post_reset_instr", instr, memWord(RESET_PC));

`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      checkOutput("fault_flag", 32'(fetch_misalign), 32'd1);
      checkOutput("fault_pc", pc, 32'h42);
      checkOutput("fault_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("fault_no_req", 32'(imem.imem_req_valid), 32'd0);
    end
`else
    waitReq("misaligned_req");
    checkOutput("misaligned_addr", imem.imem_addr, 32'h40);
    waitHold("misaligned_hold");
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
